// File: rtl/duck_pkg.sv
// ---------------------------------------------------------------------------
// duck_pkg
// Shared definitions for the duck sprite motion logic and the other game
// blocks that work alongside it.
//   duck_state_e : life-cycle state of one duck (encoding is visible on the
//                  debug/score port, so values are fixed)
//   *_DEF        : default screen geometry
//   LFSR_SEED    : reset value of the shared pseudo-random generator
//   LAUNCH_X_MIN : left-most launch column (added to 9 random bits)
// ---------------------------------------------------------------------------
package duck_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FLY    = 3'd1,
        ST_HIT    = 3'd2,
        ST_FALL   = 3'd3,
        ST_ESCAPE = 3'd4
    } duck_state_e;

    localparam int unsigned SCREEN_W_DEF = 800;
    localparam int unsigned FLOOR_Y_DEF  = 440;
    localparam int unsigned SKY_Y_DEF    = 16;

    localparam logic [15:0] LFSR_SEED    = 16'hACE1;
    localparam logic [10:0] LAUNCH_X_MIN = 11'd16;

endpackage

// File: rtl/lfsr16.sv
// ---------------------------------------------------------------------------
// lfsr16
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11), advancing on every
// pixel clock. Shared source of randomness for the game logic.
// Ports:
//   pclk  : pixel clock
//   rst_n : asynchronous active-low reset, loads LFSR_SEED
//   out   : current LFSR contents
// ---------------------------------------------------------------------------
module lfsr16
    import duck_pkg::*;
(
    input  logic        pclk,
    input  logic        rst_n,
    output logic [15:0] out
);

    logic [15:0] lfsr_q;
    logic        fb;

    // Tap 16 is the MSB; tap n maps to bit n-1.
    assign fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= {lfsr_q[14:0], fb};
        end
    end

    assign out = lfsr_q;

endmodule

// File: rtl/duck_motion_ctrl.sv
// ---------------------------------------------------------------------------
// duck_motion_ctrl
// Position generator for one duck sprite. Runs the duck's life cycle
// (launch, bouncing flight, hit freeze, fall, or escape after a timeout) and
// moves it once per video frame, on the rising edge of vsync.
// Ports:
//   pclk     : pixel clock
//   rst_n    : asynchronous active-low reset
//   vsync_in : vsync from the timing chain (frame tick = its rising edge)
//   start    : launch request, level-sampled while idle
//   hit      : single-cycle shot-on-duck pulse, honoured only in flight
//   xpos     : sprite top-left x (registered)
//   ypos     : sprite top-left y (registered)
//   invert   : 1 = sprite faces left (registered)
//   active   : 1 whenever a duck is on screen (state != IDLE)
//   done     : one-cycle pulse when a fall reaches the grass
//   escaped  : one-cycle pulse when an escape leaves the top of the screen
//   state    : current state, for debug and score logic
// ---------------------------------------------------------------------------
module duck_motion_ctrl
    import duck_pkg::*;
#(
    parameter int unsigned SCREEN_W      = SCREEN_W_DEF,
    parameter int unsigned WIDTH         = 48,
    parameter int unsigned FLOOR_Y       = FLOOR_Y_DEF,
    parameter int unsigned SKY_Y         = SKY_Y_DEF,
    parameter int unsigned SPEED_X       = 4,
    parameter int unsigned SPEED_Y       = 3,
    parameter int unsigned FALL_SPEED    = 6,
    parameter int unsigned ESCAPE_SPEED  = 8,
    parameter int unsigned FLIGHT_FRAMES = 300,
    parameter int unsigned HIT_FRAMES    = 30
) (
    input  logic        pclk,
    input  logic        rst_n,
    input  logic        vsync_in,
    input  logic        start,
    input  logic        hit,
    output logic [10:0] xpos,
    output logic [10:0] ypos,
    output logic        invert,
    output logic        active,
    output logic        done,
    output logic        escaped,
    output logic [2:0]  state
);

    // Bounds and steps are held one bit wider than the position so the
    // "position + step" comparisons can never wrap.
    localparam logic [11:0] X_MAX    = 12'(SCREEN_W - WIDTH);
    localparam logic [11:0] Y_FLOOR  = 12'(FLOOR_Y);
    localparam logic [11:0] Y_SKY    = 12'(SKY_Y);
    localparam logic [11:0] SPD_X    = 12'(SPEED_X);
    localparam logic [11:0] SPD_Y    = 12'(SPEED_Y);
    localparam logic [11:0] SPD_FALL = 12'(FALL_SPEED);
    localparam logic [11:0] SPD_ESC  = 12'(ESCAPE_SPEED);
    localparam logic [8:0]  FLIGHT_LAST = 9'(FLIGHT_FRAMES - 1);
    localparam logic [8:0]  HIT_LAST    = 9'(HIT_FRAMES - 1);

    logic [15:0] lfsr;
    logic        unused_lfsr_hi;
    logic        vsync_q;
    logic        tick;
    logic [11:0] x_ext;
    logic [11:0] y_ext;

    duck_state_e state_q,     state_d;
    logic [10:0] xpos_q,      xpos_d;
    logic [10:0] ypos_q,      ypos_d;
    logic        dir_left_q,  dir_left_d;
    logic        dir_up_q,    dir_up_d;
    logic [8:0]  frame_cnt_q, frame_cnt_d;
    logic        done_q,      done_d;
    logic        escaped_q,   escaped_d;

    lfsr16 u_lfsr (
        .pclk  (pclk),
        .rst_n (rst_n),
        .out   (lfsr)
    );

    // Only the low nine bits pick the launch column; the rest are for
    // other consumers of the shared generator.
    assign unused_lfsr_hi = ^lfsr[15:9];

    assign tick  = vsync_in & ~vsync_q;
    assign x_ext = {1'b0, xpos_q};
    assign y_ext = {1'b0, ypos_q};

    always_comb begin
        state_d     = state_q;
        xpos_d      = xpos_q;
        ypos_d      = ypos_q;
        dir_left_d  = dir_left_q;
        dir_up_d    = dir_up_q;
        frame_cnt_d = frame_cnt_q;
        done_d      = 1'b0;
        escaped_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_FLY;
                    // 16 + 9 random bits spans 16..527, always on screen.
                    xpos_d      = LAUNCH_X_MIN + {2'b00, lfsr[8:0]};
                    ypos_d      = 11'(Y_FLOOR);
                    dir_left_d  = lfsr[0];
                    dir_up_d    = 1'b1;
                    frame_cnt_d = '0;
                end
            end

            ST_FLY: begin
                // A shot wins over a coincident frame tick or timeout.
                if (hit) begin
                    state_d     = ST_HIT;
                    frame_cnt_d = '0;
                end else if (tick) begin
                    if (dir_left_q) begin
                        if (x_ext <= SPD_X) begin
                            xpos_d     = '0;
                            dir_left_d = 1'b0;
                        end else begin
                            xpos_d = 11'(x_ext - SPD_X);
                        end
                    end else begin
                        if (x_ext + SPD_X >= X_MAX) begin
                            xpos_d     = 11'(X_MAX);
                            dir_left_d = 1'b1;
                        end else begin
                            xpos_d = 11'(x_ext + SPD_X);
                        end
                    end

                    if (dir_up_q) begin
                        if (y_ext <= Y_SKY + SPD_Y) begin
                            ypos_d   = 11'(Y_SKY);
                            dir_up_d = 1'b0;
                        end else begin
                            ypos_d = 11'(y_ext - SPD_Y);
                        end
                    end else begin
                        if (y_ext + SPD_Y >= Y_FLOOR) begin
                            ypos_d   = 11'(Y_FLOOR);
                            dir_up_d = 1'b1;
                        end else begin
                            ypos_d = 11'(y_ext + SPD_Y);
                        end
                    end

                    if (frame_cnt_q == FLIGHT_LAST) begin
                        state_d     = ST_ESCAPE;
                        frame_cnt_d = '0;
                    end else begin
                        frame_cnt_d = frame_cnt_q + 9'd1;
                    end
                end
            end

            ST_HIT: begin
                if (tick) begin
                    if (frame_cnt_q == HIT_LAST) begin
                        state_d     = ST_FALL;
                        frame_cnt_d = '0;
                    end else begin
                        frame_cnt_d = frame_cnt_q + 9'd1;
                    end
                end
            end

            ST_FALL: begin
                if (tick) begin
                    if (y_ext + SPD_FALL >= Y_FLOOR) begin
                        ypos_d  = 11'(Y_FLOOR);
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        ypos_d = 11'(y_ext + SPD_FALL);
                    end
                end
            end

            ST_ESCAPE: begin
                if (tick) begin
                    if (y_ext <= SPD_ESC) begin
                        ypos_d    = '0;
                        state_d   = ST_IDLE;
                        escaped_d = 1'b1;
                    end else begin
                        ypos_d = 11'(y_ext - SPD_ESC);
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q     <= 1'b0;
            state_q     <= ST_IDLE;
            xpos_q      <= '0;
            ypos_q      <= 11'(FLOOR_Y);
            dir_left_q  <= 1'b0;
            dir_up_q    <= 1'b1;
            frame_cnt_q <= '0;
            done_q      <= 1'b0;
            escaped_q   <= 1'b0;
        end else begin
            vsync_q     <= vsync_in;
            state_q     <= state_d;
            xpos_q      <= xpos_d;
            ypos_q      <= ypos_d;
            dir_left_q  <= dir_left_d;
            dir_up_q    <= dir_up_d;
            frame_cnt_q <= frame_cnt_d;
            done_q      <= done_d;
            escaped_q   <= escaped_d;
        end
    end

    // The sprite always faces its direction of travel.
    assign xpos    = xpos_q;
    assign ypos    = ypos_q;
    assign invert  = dir_left_q;
    assign active  = (state_q != ST_IDLE);
    assign done    = done_q;
    assign escaped = escaped_q;
    assign state   = state_q;

endmodule

// File: tb/tb_duck_motion_ctrl.sv
module tb_duck_motion_ctrl;

    localparam int S_IDLE = 0;
    localparam int S_FLY  = 1;
    localparam int S_HIT  = 2;
    localparam int S_FALL = 3;
    localparam int S_ESC  = 4;

    localparam int RIGHT_WALL = 800 - 48;
    localparam int FLOOR      = 440;
    localparam int SKY        = 16;

    logic        pclk     = 1'b0;
    logic        rst_n    = 1'b1;
    logic        vsync_in = 1'b0;
    logic        start    = 1'b0;
    logic        hit      = 1'b0;
    logic [10:0] xpos;
    logic [10:0] ypos;
    logic        invert;
    logic        active;
    logic        done;
    logic        escaped;
    logic [2:0]  state;

    int checks = 0;
    int errors = 0;

    // Behavioural model of one duck: position, signed velocity per frame,
    // frame counter, pulses and the random generator as an integer.
    int m_st, m_x, m_y, m_dx, m_dy, m_fc, m_done, m_esc, m_lfsr, m_vs_prev;

    duck_motion_ctrl dut (
        .pclk     (pclk),
        .rst_n    (rst_n),
        .vsync_in (vsync_in),
        .start    (start),
        .hit      (hit),
        .xpos     (xpos),
        .ypos     (ypos),
        .invert   (invert),
        .active   (active),
        .done     (done),
        .escaped  (escaped),
        .state    (state)
    );

    always #5 pclk = ~pclk;

    function automatic void check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endfunction

    function automatic void model_reset();
        m_st = S_IDLE; m_x = 0; m_y = FLOOR; m_dx = 4; m_dy = -3;
        m_fc = 0; m_done = 0; m_esc = 0; m_lfsr = 'hACE1; m_vs_prev = 0;
    endfunction

    function automatic void model_step();
        int tick, l, nx, ny;
        tick      = (vsync_in && !m_vs_prev) ? 1 : 0;
        m_vs_prev = int'(vsync_in);
        l         = m_lfsr;
        m_lfsr    = ((l << 1) | ($countones(l & 'hB400) % 2)) & 'hFFFF;
        m_done    = 0;
        m_esc     = 0;
        case (m_st)
            S_IDLE: if (start) begin
                m_st = S_FLY; m_x = 16 + (l & 511); m_y = FLOOR;
                m_dx = (l & 1) ? -4 : 4; m_dy = -3; m_fc = 0;
            end
            S_FLY: if (hit) begin
                m_st = S_HIT; m_fc = 0;
            end else if (tick) begin
                nx = m_x + m_dx;
                if (nx >= RIGHT_WALL) begin m_x = RIGHT_WALL; m_dx = -4; end
                else if (nx <= 0)     begin m_x = 0;          m_dx = 4;  end
                else m_x = nx;
                ny = m_y + m_dy;
                if (ny <= SKY)        begin m_y = SKY;   m_dy = 3;  end
                else if (ny >= FLOOR) begin m_y = FLOOR; m_dy = -3; end
                else m_y = ny;
                if (m_fc == 299) begin m_st = S_ESC; m_fc = 0; end
                else m_fc++;
            end
            S_HIT: if (tick) begin
                if (m_fc == 29) begin m_st = S_FALL; m_fc = 0; end
                else m_fc++;
            end
            S_FALL: if (tick) begin
                if (m_y + 6 >= FLOOR) begin m_y = FLOOR; m_st = S_IDLE; m_done = 1; end
                else m_y += 6;
            end
            S_ESC: if (tick) begin
                if (m_y <= 8) begin m_y = 0; m_st = S_IDLE; m_esc = 1; end
                else m_y -= 8;
            end
            default: m_st = S_IDLE;
        endcase
    endfunction

    function automatic void compare_all();
        check("state",   int'(state),   m_st);
        check("xpos",    int'(xpos),    m_x);
        check("ypos",    int'(ypos),    m_y);
        check("invert",  int'(invert),  (m_dx < 0) ? 1 : 0);
        check("active",  int'(active),  (m_st != S_IDLE) ? 1 : 0);
        check("done",    int'(done),    m_done);
        check("escaped", int'(escaped), m_esc);
    endfunction

    task automatic cyc();
        @(posedge pclk);
        if (rst_n) model_step();
        @(negedge pclk);
        compare_all();
    endtask

    task automatic tick1();
        vsync_in = 1'b1;
        cyc();
        vsync_in = 1'b0;
        cyc();
    endtask

    task automatic check_reset_values(string tag);
        check({tag, "_state"},  int'(state),   S_IDLE);
        check({tag, "_xpos"},   int'(xpos),    0);
        check({tag, "_ypos"},   int'(ypos),    FLOOR);
        check({tag, "_invert"}, int'(invert),  0);
        check({tag, "_active"}, int'(active),  0);
        check({tag, "_done"},   int'(done),    0);
        check({tag, "_esc"},    int'(escaped), 0);
    endtask

    task automatic do_reset();
        start = 1'b0; hit = 1'b0; vsync_in = 1'b0;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_reset_values("rst");
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    // Launch with a known-aligned, right-moving duck: LFSR bits [1:0] = 0
    // gives a launch column that is a multiple of 4 and dir_left = 0.
    task automatic launch_aligned();
        int ok;
        for (int k = 0; k < 200 && (m_lfsr & 3) != 0; k++) cyc();
        ok = ((m_lfsr & 3) == 0) ? 1 : 0;
        check("lfsr_align_wait", ok, 1);
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    typedef struct {
        bit st;
        bit ht;
        bit vs;
        int exp_state;
        bit exp_active;
    } vec_t;

    vec_t tbl[10];

    initial begin
        int l, reached, fin, prev_y;

        tbl[0] = '{0, 0, 1, S_IDLE, 0};
        tbl[1] = '{0, 0, 0, S_IDLE, 0};
        tbl[2] = '{0, 1, 1, S_IDLE, 0};
        tbl[3] = '{1, 0, 0, S_FLY,  1};
        tbl[4] = '{1, 0, 0, S_FLY,  1};
        tbl[5] = '{0, 0, 1, S_FLY,  1};
        tbl[6] = '{0, 1, 1, S_HIT,  1};
        tbl[7] = '{0, 0, 0, S_HIT,  1};
        tbl[8] = '{1, 1, 1, S_HIT,  1};
        tbl[9] = '{0, 0, 0, S_HIT,  1};

        #1;
        do_reset();

        // Basic state walk
        for (int i = 0; i < 10; i++) begin
            start = tbl[i].st; hit = tbl[i].ht; vsync_in = tbl[i].vs;
            cyc();
            check("tbl_state",  int'(state),  tbl[i].exp_state);
            check("tbl_active", int'(active), int'(tbl[i].exp_active));
        end
        start = 1'b0; hit = 1'b0; vsync_in = 1'b0;

        // Launch column and facing come from the generator
        for (int r = 0; r < 3; r++) begin
            do_reset();
            repeat ($urandom_range(0, 40)) cyc();
            l = m_lfsr;
            start = 1'b1;
            cyc();
            start = 1'b0;
            check("launch_x",      int'(xpos), 16 + (l & 511));
            check("launch_range",  (xpos >= 11'd16 && xpos <= 11'd527) ? 1 : 0, 1);
            check("launch_invert", int'(invert), l & 1);
            check("launch_y",      int'(ypos), FLOOR);
        end

        // Right-wall bounce from 740
        do_reset();
        launch_aligned();
        for (int k = 0; k < 400 && !(m_x == 740 && m_dx > 0); k++) tick1();
        reached = (m_x == 740 && m_dx > 0) ? 1 : 0;
        check("wall_reach", reached, 1);
        tick1(); check("wall_t1_x", int'(xpos), 744); check("wall_t1_inv", int'(invert), 0);
        tick1(); check("wall_t2_x", int'(xpos), 748);
        tick1(); check("wall_t3_x", int'(xpos), 752); check("wall_t3_inv", int'(invert), 1);
        tick1(); check("wall_t4_x", int'(xpos), 748); check("wall_t4_inv", int'(invert), 1);

        // Hit coinciding with a frame tick at x = 300, then freeze and fall
        do_reset();
        launch_aligned();
        for (int k = 0; k < 400 && m_x != 300; k++) tick1();
        check("hit_reach", (m_x == 300) ? 1 : 0, 1);
        vsync_in = 1'b1; hit = 1'b1;
        cyc();
        vsync_in = 1'b0; hit = 1'b0;
        check("hit_state", int'(state), S_HIT);
        check("hit_x",     int'(xpos),  300);
        cyc();
        repeat (29) tick1();
        check("hit_hold_state", int'(state), S_HIT);
        check("hit_hold_x",     int'(xpos),  300);
        tick1();
        check("fall_state", int'(state), S_FALL);

        fin = 0;
        for (int k = 0; k < 120 && fin == 0; k++) begin
            vsync_in = 1'b1;
            cyc();
            vsync_in = 1'b0;
            if (m_st == S_IDLE) begin
                check("fall_end_y",      int'(ypos),   FLOOR);
                check("fall_end_state",  int'(state),  S_IDLE);
                check("fall_end_done",   int'(done),   1);
                check("fall_end_active", int'(active), 0);
                cyc();
                check("fall_done_once",  int'(done),   0);
                fin = 1;
            end else begin
                cyc();
            end
        end
        check("fall_finished", fin, 1);

        // Timeout to escape; a shot while escaping changes nothing
        do_reset();
        start = 1'b1;
        cyc();
        start = 1'b0;
        repeat (299) tick1();
        check("timeout_299_state", int'(state), S_FLY);
        tick1();
        check("timeout_300_state", int'(state), S_ESC);
        prev_y = m_y;
        vsync_in = 1'b1; hit = 1'b1;
        cyc();
        vsync_in = 1'b0; hit = 1'b0;
        check("esc_hit_state", int'(state), S_ESC);
        check("esc_hit_y",     int'(ypos),  prev_y - 8);
        cyc();
        fin = 0;
        for (int k = 0; k < 100 && fin == 0; k++) begin
            prev_y = m_y;
            vsync_in = 1'b1;
            cyc();
            vsync_in = 1'b0;
            if (prev_y <= 8) begin
                check("esc_end_y",     int'(ypos),    0);
                check("esc_end_state", int'(state),   S_IDLE);
                check("esc_end_pulse", int'(escaped), 1);
                cyc();
                check("esc_pulse_once", int'(escaped), 0);
                fin = 1;
            end else begin
                check("esc_step_y", int'(ypos), prev_y - 8);
                cyc();
            end
        end
        check("esc_finished", fin, 1);

        // Asynchronous reset in the middle of a flight
        do_reset();
        start = 1'b1;
        cyc();
        start = 1'b0;
        repeat (5) tick1();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_reset_values("midfly");
        cyc();
        rst_n = 1'b1;
        repeat (4) tick1();
        check("post_rst_state", int'(state), S_IDLE);
        check("post_rst_x",     int'(xpos),  0);
        check("post_rst_y",     int'(ypos),  FLOOR);

        // Random traffic against the model
        do_reset();
        for (int i = 0; i < 30000; i++) begin
            start    = ($urandom_range(0, 7) == 0);
            hit      = ((i % 8000) < 4000) && ($urandom_range(0, 299) == 0);
            vsync_in = ($urandom_range(0, 4) == 0);
            cyc();
        end
        start = 1'b0; hit = 1'b0; vsync_in = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
